instr_mem_loader: RTL and testbench

//  Writer side of the CPU's instruction memory. The CPU only reads that memory (write enable tied low).

---
 rtl/instr_mem_loader_pkg.sv | 12 +
 rtl/instr_mem_loader_register_custom_width.sv | 20 ++
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction memory loader.
// The state encoding is identical whether or not LDR_CHECKSUM_EN is defined.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE   = 2'd0,
        LDR_LOAD   = 2'd1,
        LDR_CHECK  = 2'd2,
        LDR_FINISH = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_register_custom_width.sv
// Generic enabled register with synchronous active-high reset.
module register_custom_width #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Writes a byte stream into the CPU instruction memory while holding the CPU in reset.
// Define LDR_CHECKSUM_EN to expect a trailing checksum beat and report mismatches on error_o.
//
// state      | meaning
// LDR_IDLE   | CPU running, waiting for start
// LDR_LOAD   | accepting data beats, one memory write per beat
// LDR_CHECK  | accepting the checksum beat (LDR_CHECKSUM_EN only)
// LDR_FINISH | one-cycle done pulse, CPU still held
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  len_en;
    logic                  last_beat;

    assign len_d     = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign last_beat = ({1'b0, count_q} == (len_q - 1'b1));

    register_custom_width #(
        .WIDTH (ADDR_WIDTH + 1)
    ) u_len_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (len_en),
        .d_i     (len_d),
        .q_o     (len_q)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LDR_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_en      = 1'b0;
        in_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (start_i) begin
                    len_en  = 1'b1;
                    count_d = '0;
                    state_d = (len_d == '0) ? LDR_FINISH : LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mem_we_o    = 1'b1;
                    mem_addr_o  = count_q;
                    mem_wdata_o = in_data_i;
                    // count wraps naturally at DEPTH; last_beat exits before any re-write
                    count_d     = count_q + 1'b1;
                    if (last_beat) begin
`ifdef LDR_CHECKSUM_EN
                        state_d = LDR_CHECK;
`else
                        state_d = LDR_FINISH;
`endif
                    end
                end
            end
            LDR_CHECK: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_d = LDR_FINISH;
                end
            end
            LDR_FINISH: begin
                done_o  = 1'b1;
                state_d = LDR_IDLE;
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    assign busy_o     = (state_q != LDR_IDLE);
    assign cpu_hold_o = (state_q != LDR_IDLE);

`ifdef LDR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  error_q, error_d;

    always_comb begin
        sum_d   = sum_q;
        error_d = error_q;
        if (state_q == LDR_IDLE && start_i) begin
            sum_d   = '0;
            error_d = 1'b0;
        end else if (state_q == LDR_LOAD && in_valid_i) begin
            sum_d = sum_q + in_data_i;
        end else if (state_q == LDR_CHECK && in_valid_i && (in_data_i != sum_q)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; the bench itself plays the instruction memory.
// Works in both builds, with or without LDR_CHECKSUM_EN.
module tb_instr_mem_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef LDR_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;

    instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] shadow_mem [DEPTH];
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    int            n_writes = 0, n_done = 0, n_hold = 0;
    bit            mon_en = 1'b0;
    bit            sending_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: every write must match the next word the stimulus promised.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("we_vs_handshake", 32'(mem_we_o), 32'(in_valid_i & in_ready_o & !sending_check));
            chk("hold_eq_busy", 32'(cpu_hold_o), 32'(busy_o));
            if (!busy_o) chk("idle_quiet", 32'({in_ready_o, done_o, mem_we_o}), 32'd0);
`ifndef LDR_CHECKSUM_EN
            chk("error_tied", 32'(error_o), 32'd0);
`endif
            if (mem_we_o) begin
                chk("write_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) begin
                    chk("write_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
                    chk("write_data", 32'(mem_wdata_o), 32'(exp_data_q.pop_front()));
                end
                shadow_mem[mem_addr_o] = mem_wdata_o;
                n_writes++;
            end
            if (done_o) n_done++;
            if (cpu_hold_o) n_hold++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] l);
        start_i = 1'b1;
        len_i   = l;
        tick();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit is_chk);
        bit ok;
        ok            = 1'b0;
        in_valid_i    = 1'b1;
        in_data_i     = d;
        sending_check = is_chk;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = in_ready_o;
            tick();
        end
        in_valid_i    = 1'b0;
        sending_check = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready never seen for data %0h", d);
        end
    endtask

    task automatic data_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        send(d, 1'b0);
    endtask

    task automatic finish_check(input string name);
        @(negedge clk_i);
        chk({name, "_done"}, 32'(done_o), 32'd1);
        chk({name, "_fin_hold"}, 32'(cpu_hold_o), 32'd1);
        chk({name, "_fin_ready"}, 32'(in_ready_o), 32'd0);
        tick();
        @(negedge clk_i);
        chk({name, "_released"}, 32'(cpu_hold_o), 32'd0);
    endtask

    int            h0, d0, w0;
    logic [DW-1:0] s, d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_hold", 32'(cpu_hold_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        tick();
        reset_i = 1'b0;
        mon_en  = 1'b1;

        // T1: three back-to-back beats, hold = 3 LOAD + CHECK + FINISH
        h0 = n_hold; d0 = n_done; w0 = n_writes;
        do_start(5'd3);
        data_beat(4'd0, 8'h12);
        data_beat(4'd1, 8'h34);
        data_beat(4'd2, 8'h56);
`ifdef LDR_CHECKSUM_EN
        send(8'h9C, 1'b1);
`endif
        finish_check("t1");
        chk("t1_hold_cycles", 32'(n_hold - h0), 32'(4 + CHK));
        chk("t1_done_count", 32'(n_done - d0), 32'd1);
        chk("t1_writes", 32'(n_writes - w0), 32'd3);
        chk("t1_mem0", 32'(shadow_mem[0]), 32'h12);
        chk("t1_mem1", 32'(shadow_mem[1]), 32'h34);
        chk("t1_mem2", 32'(shadow_mem[2]), 32'h56);
        chk("t1_error", 32'(error_o), 32'd0);

        // T2: gapped stream, three idle cycles between the two beats
        h0 = n_hold; d0 = n_done; w0 = n_writes;
        do_start(5'd2);
        data_beat(4'd0, 8'hA5);
        repeat (3) tick();
        data_beat(4'd1, 8'h5A);
`ifdef LDR_CHECKSUM_EN
        send(8'hFF, 1'b1);
`endif
        finish_check("t2");
        chk("t2_hold_cycles", 32'(n_hold - h0), 32'(6 + CHK));
        chk("t2_done_count", 32'(n_done - d0), 32'd1);
        chk("t2_writes", 32'(n_writes - w0), 32'd2);
        chk("t2_mem0", 32'(shadow_mem[0]), 32'hA5);
        chk("t2_mem1", 32'(shadow_mem[1]), 32'h5A);

        // T3: len 20 clamps to a full 16-word load; a start mid-load is ignored
        h0 = n_hold; d0 = n_done; w0 = n_writes;
        s = '0;
        do_start(5'd20);
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'(i * 7 + 3);
            s = s + d;
            if (i == 6) begin
                start_i = 1'b1;
                len_i   = 5'd2;
            end
            data_beat(AW'(i), d);
            start_i = 1'b0;
            len_i   = '0;
        end
`ifdef LDR_CHECKSUM_EN
        send(s, 1'b1);
`endif
        finish_check("t3");
        chk("t3_done_count", 32'(n_done - d0), 32'd1);
        chk("t3_writes", 32'(n_writes - w0), 32'd16);
        chk("t3_hold_cycles", 32'(n_hold - h0), 32'(17 + CHK));
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_mem", 32'(shadow_mem[i]), 32'(i * 7 + 3));
        end
        chk("t3_mem15_literal", 32'(shadow_mem[15]), 32'h6C);
        chk("t3_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("t3_error", 32'(error_o), 32'd0);

        // T4: len 0 is a bare one-cycle CPU reset pulse
        h0 = n_hold; d0 = n_done; w0 = n_writes;
        do_start(5'd0);
        finish_check("t4");
        chk("t4_hold_cycles", 32'(n_hold - h0), 32'd1);
        chk("t4_done_count", 32'(n_done - d0), 32'd1);
        chk("t4_writes", 32'(n_writes - w0), 32'd0);

        // T5: reset after two of four beats aborts without done
        d0 = n_done; w0 = n_writes;
        do_start(5'd4);
        data_beat(4'd0, 8'hC1);
        data_beat(4'd1, 8'hC2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_hold", 32'(cpu_hold_o), 32'd0);
        chk("t5_ready", 32'(in_ready_o), 32'd0);
        chk("t5_done", 32'(done_o), 32'd0);
        chk("t5_done_count", 32'(n_done - d0), 32'd0);
        chk("t5_writes", 32'(n_writes - w0), 32'd2);
        chk("t5_mem0", 32'(shadow_mem[0]), 32'hC1);
        chk("t5_mem1", 32'(shadow_mem[1]), 32'hC2);
        chk("t5_mem2_kept", 32'(shadow_mem[2]), 32'h11);

        // Simultaneous reset and start: reset wins
        tick();
        reset_i = 1'b1;
        start_i = 1'b1;
        len_i   = 5'd3;
        tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        len_i   = '0;
        @(negedge clk_i);
        chk("rst_start_busy", 32'(busy_o), 32'd0);
        tick();

`ifdef LDR_CHECKSUM_EN
        // T6: good checksum, then a bad one that stays sticky until next start
        do_start(5'd2);
        data_beat(4'd0, 8'h10);
        data_beat(4'd1, 8'h20);
        send(8'h30, 1'b1);
        finish_check("t6a");
        chk("t6a_error", 32'(error_o), 32'd0);
        do_start(5'd2);
        data_beat(4'd0, 8'h10);
        data_beat(4'd1, 8'h20);
        send(8'h31, 1'b1);
        @(negedge clk_i);
        chk("t6b_error_fin", 32'(error_o), 32'd1);
        tick();
        repeat (3) tick();
        @(negedge clk_i);
        chk("t6b_error_sticky", 32'(error_o), 32'd1);
        do_start(5'd0);
        @(negedge clk_i);
        chk("t6c_error_cleared", 32'(error_o), 32'd0);
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
